// File: rtl/display_pkg.sv
// Shared types and helpers for the multiplexed seven-segment scan path.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  // Anodes are active-low, so a 1 turns the digit off.
  localparam logic ANODE_OFF = 1'b1;

  function automatic int tick_div(input int clk_freq, input int freq);
    return clk_freq / freq;
  endfunction

  function automatic int timer_width(input int ticks);
    return (ticks > 1) ? $clog2(ticks) : 1;
  endfunction

endpackage

// File: rtl/display_scan_timer.sv
// Slot timer: counts 0..TICK_DIV-1 per digit slot and flags the end of blanking
// and the end of the slot.
module scan_timer
  import display_pkg::*;
#(
  parameter int TICK_DIV     = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  output logic o_blank_end,
  output logic o_slot_end
);

  localparam int TW = timer_width(TICK_DIV);
  localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYCLES - 1);
  localparam logic [TW-1:0] SLOT_LAST  = TW'(TICK_DIV - 1);

  logic [TW-1:0] r_timer;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= '0;
    end else if (i_clear || o_slot_end) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + TW'(1);
    end
  end

  assign o_blank_end = (r_timer == BLANK_LAST);
  assign o_slot_end  = (r_timer == SLOT_LAST);

endmodule

// File: rtl/display_scan_controller.sv
// Digit scan sequencer with anti-ghost blanking, leading-zero suppression and
// a frame-synchronous double-buffered load from the BCD producer.
module display_scan_controller
  import display_pkg::*;
#(
  parameter int CLK_FREQ     = 100000000,
  parameter int SCAN_FREQ    = 1000,
  parameter int N_DIGITS     = 4,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                        clk_in,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        blank_lz,
  input  logic [4*N_DIGITS-1:0]       value_in,
  input  logic                        load_valid,
  output logic                        load_ready,
  output logic [$clog2(N_DIGITS)-1:0] digit_sel,
  output logic [3:0]                  bcd_out,
  output logic [N_DIGITS-1:0]         anode,
  output logic                        frame_done
);

  localparam int TICK_DIV = tick_div(CLK_FREQ, SCAN_FREQ);
  localparam int DW       = $clog2(N_DIGITS);
  localparam logic [DW-1:0] LAST_DIGIT = DW'(N_DIGITS - 1);

  if (N_DIGITS < 2) begin : g_bad_digits
    $error("display_scan_controller: N_DIGITS must be at least 2");
  end
  if (BLANK_CYCLES <= 0 || BLANK_CYCLES >= TICK_DIV) begin : g_bad_blank
    $error("display_scan_controller: need 0 < BLANK_CYCLES < TICK_DIV");
  end

  state_t                r_state, w_state_next;
  logic [DW-1:0]         r_digit, w_digit_next;
  logic [4*N_DIGITS-1:0] r_active, r_shadow, w_active_next;
  logic                  r_pending;
  logic [N_DIGITS-1:0]   r_anode, w_anode_next, w_suppress;
  logic [3:0]            r_bcd, w_bcd_next;
  logic                  w_clear, w_blank_end, w_slot_end, w_frame_end;

  assign w_clear     = !enable || (r_state == IDLE);
  assign w_frame_end = enable && (r_state == SHOW) && w_slot_end && (r_digit == LAST_DIGIT);

  scan_timer #(
    .TICK_DIV    (TICK_DIV),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_scan_timer (
    .clk        (clk_in),
    .rst_n      (reset),
    .i_clear    (w_clear),
    .o_blank_end(w_blank_end),
    .o_slot_end (w_slot_end)
  );

  // NOTE: every signal driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_digit_next = r_digit;
    if (!enable) begin
      w_state_next = IDLE;
      w_digit_next = '0;
    end else begin
      case (r_state)
        IDLE:    w_state_next = BLANK;
        BLANK:   if (w_blank_end) w_state_next = SHOW;
        SHOW: begin
          if (w_slot_end) begin
            w_state_next = BLANK;
            w_digit_next = (r_digit == LAST_DIGIT) ? '0 : r_digit + DW'(1);
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  assign w_active_next = (w_frame_end && r_pending) ? r_shadow : r_active;

  // A digit is dark when it and every more-significant digit are zero.
  always_comb begin
    logic zero_run;
    w_suppress = '0;
    zero_run   = 1'b1;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      zero_run      = zero_run && (w_active_next[4*i +: 4] == 4'd0);
      w_suppress[i] = blank_lz && zero_run;
    end
  end

  // Outputs are registered from next-cycle values so they line up with the
  // registered state and digit_sel without a cycle of lag.
  always_comb begin
    w_bcd_next   = w_active_next[{w_digit_next, 2'b00} +: 4];
    w_anode_next = {N_DIGITS{ANODE_OFF}};
    if (w_state_next == SHOW && !w_suppress[w_digit_next]) begin
      w_anode_next[w_digit_next] = ~ANODE_OFF;
    end
  end

  // NOTE: the display buffers are reset too, so the panel never shows
  // power-up garbage and a reset always discards an in-flight load.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_digit   <= '0;
      r_active  <= '0;
      r_shadow  <= '0;
      r_pending <= 1'b0;
      r_anode   <= {N_DIGITS{ANODE_OFF}};
      r_bcd     <= 4'd0;
    end else begin
      r_state  <= w_state_next;
      r_digit  <= w_digit_next;
      r_active <= w_active_next;
      r_anode  <= w_anode_next;
      r_bcd    <= w_bcd_next;
      if (w_frame_end && r_pending) begin
        r_pending <= 1'b0;
      end else if (load_valid && !r_pending) begin
        r_shadow  <= value_in;
        r_pending <= 1'b1;
      end
    end
  end

  assign load_ready = !r_pending;
  assign digit_sel  = r_digit;
  assign bcd_out    = r_bcd;
  assign anode      = r_anode;
  assign frame_done = w_frame_end;

endmodule

// File: tb/tb_display_scan_controller.sv
// Self-checking bench for display_scan_controller: frame-position model feeding
// a scoreboard queue, a vector table for the first frame, and corner sequences.
module tb_display_scan_controller;

  localparam int CLK_FREQ     = 1000;
  localparam int SCAN_FREQ    = 100;
  localparam int N_DIGITS     = 4;
  localparam int BLANK_CYCLES = 2;
  localparam int TICK         = 10;
  localparam int FRAME        = 40;

  logic        clk_in     = 1'b0;
  logic        reset      = 1'b1;
  logic        enable     = 1'b0;
  logic        blank_lz   = 1'b0;
  logic        load_valid = 1'b0;
  logic [15:0] value_in   = '0;
  logic        load_ready;
  logic [1:0]  digit_sel;
  logic [3:0]  bcd_out;
  logic [3:0]  anode;
  logic        frame_done;

  always #5 clk_in = ~clk_in;

  display_scan_controller #(
    .CLK_FREQ    (CLK_FREQ),
    .SCAN_FREQ   (SCAN_FREQ),
    .N_DIGITS    (N_DIGITS),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .enable    (enable),
    .blank_lz  (blank_lz),
    .value_in  (value_in),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .digit_sel (digit_sel),
    .bcd_out   (bcd_out),
    .anode     (anode),
    .frame_done(frame_done)
  );

  typedef struct {
    logic [1:0] digit;
    logic [3:0] anode;
    logic [3:0] bcd;
    logic       ready;
    logic       fd;
  } exp_t;

  typedef struct {
    int         n;
    logic [3:0] anode;
    logic [1:0] digit;
    logic       fd;
  } vec_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   lit[4];

  // Model: position within a 40-cycle frame rather than an explicit FSM.
  bit          m_run;
  int          m_pos;
  logic [15:0] m_active, m_shadow;
  bit          m_pending;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  function automatic void model_reset();
    m_run     = 1'b0;
    m_pos     = 0;
    m_active  = '0;
    m_shadow  = '0;
    m_pending = 1'b0;
  endfunction

  function automatic exp_t model_out(input logic lz, input logic en);
    exp_t e;
    int   d, slot;
    d       = m_run ? m_pos / TICK : 0;
    slot    = m_pos % TICK;
    e.digit = 2'(d);
    e.bcd   = 4'(m_active >> (4 * d));
    e.anode = 4'hF;
    if (m_run && slot >= BLANK_CYCLES && !(lz && d != 0 && (m_active >> (4 * d)) == 16'h0))
      e.anode[d] = 1'b0;
    e.ready = !m_pending;
    e.fd    = en && m_run && (m_pos == FRAME - 1);
    return e;
  endfunction

  function automatic void model_edge();
    bit fe;
    fe = enable && m_run && (m_pos == FRAME - 1);
    if (fe && m_pending) begin
      m_active  = m_shadow;
      m_pending = 1'b0;
    end else if (load_valid && !m_pending) begin
      m_shadow  = value_in;
      m_pending = 1'b1;
    end
    if (!enable) begin
      m_run = 1'b0;
      m_pos = 0;
    end else if (!m_run) begin
      m_run = 1'b1;
      m_pos = 0;
    end else begin
      m_pos = (m_pos + 1) % FRAME;
    end
  endfunction

  // One clock: predict, push, clock, pop and compare.
  task automatic step();
    exp_t e;
    model_edge();
    sb_q.push_back(model_out(blank_lz, enable));
    @(posedge clk_in);
    #1;
    e = sb_q.pop_front();
    check("sb_digit_sel", 32'(digit_sel), 32'(e.digit));
    check("sb_anode", 32'(anode), 32'(e.anode));
    check("sb_bcd_out", 32'(bcd_out), 32'(e.bcd));
    check("sb_load_ready", 32'(load_ready), 32'(e.ready));
    check("sb_frame_done", 32'(frame_done), 32'(e.fd));
  endtask

  task automatic goto_pos(input int target);
    int k = 0;
    while (!(m_run && m_pos == target) && k < FRAME + 5) begin
      step();
      k++;
    end
  endtask

  task automatic wait_frame_done();
    int k = 0;
    while (frame_done !== 1'b1 && k < FRAME + 5) begin
      step();
      k++;
    end
    check("wait_frame_done", 32'(frame_done), 32'd1);
  endtask

  function automatic void tally();
    for (int d = 0; d < 4; d++) if (anode[d] == 1'b0) lit[d]++;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t t1[10];
    logic [3:0] exp_nib[4];
    t1 = '{
      '{2, 4'hF, 2'd0, 1'b0}, '{8, 4'hE, 2'd0, 1'b0},
      '{2, 4'hF, 2'd1, 1'b0}, '{8, 4'hD, 2'd1, 1'b0},
      '{2, 4'hF, 2'd2, 1'b0}, '{8, 4'hB, 2'd2, 1'b0},
      '{2, 4'hF, 2'd3, 1'b0}, '{7, 4'h7, 2'd3, 1'b0},
      '{1, 4'h7, 2'd3, 1'b1}, '{2, 4'hF, 2'd0, 1'b0}
    };
    exp_nib = '{4'h4, 4'h3, 4'h2, 4'h1};
    model_reset();

    // Reset values
    #2 reset = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    check("rst_anode", 32'(anode), 32'hF);
    check("rst_digit_sel", 32'(digit_sel), 32'd0);
    check("rst_bcd_out", 32'(bcd_out), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_load_ready", 32'(load_ready), 32'd1);
    reset  = 1'b1;
    enable = 1'b1;

    // 1: first frame timing from the vector table
    for (int r = 0; r < 10; r++) begin
      for (int k = 0; k < t1[r].n; k++) begin
        step();
        check("t1_anode", 32'(anode), 32'(t1[r].anode));
        check("t1_digit_sel", 32'(digit_sel), 32'(t1[r].digit));
        check("t1_frame_done", 32'(frame_done), 32'(t1[r].fd));
      end
    end

    // 2: single-cycle load of 1234, committed at the frame boundary
    value_in   = 16'h1234;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    check("t2_ready_low", 32'(load_ready), 32'd0);
    wait_frame_done();
    check("t2_ready_low_at_boundary", 32'(load_ready), 32'd0);
    step();
    check("t2_ready_rises", 32'(load_ready), 32'd1);
    for (int d = 0; d < 4; d++) begin
      goto_pos(d * TICK + 2);
      check("t2_bcd_digit", 32'(bcd_out), 32'(exp_nib[d]));
    end

    // 4 + 3a: load 0050, hold 9999 while pending, then blank leading zeros
    value_in   = 16'h0050;
    load_valid = 1'b1;
    step();
    check("t4_first_accept", 32'(load_ready), 32'd0);
    value_in = 16'h9999;
    step();
    check("t4_hold_ignored", 32'(load_ready), 32'd0);
    wait_frame_done();
    blank_lz = 1'b1;
    step();
    check("t4_ready_rises", 32'(load_ready), 32'd1);
    step();
    check("t4_held_accepted", 32'(load_ready), 32'd0);
    load_valid = 1'b0;
    lit = '{0, 0, 0, 0};
    tally();
    for (int k = 0; k < FRAME - 2; k++) begin
      step();
      tally();
      if (m_pos == 2)  check("t3_digit0_zero", 32'(bcd_out), 32'd0);
      if (m_pos == 12) check("t3_digit1_five", 32'(bcd_out), 32'd5);
    end
    check("t3_lit_d0", 32'(lit[0]), 32'd8);
    check("t3_lit_d1", 32'(lit[1]), 32'd8);
    check("t3_lit_d2", 32'(lit[2]), 32'd0);
    check("t3_lit_d3", 32'(lit[3]), 32'd0);
    step();
    goto_pos(2);
    check("t4_9999_shown", 32'(bcd_out), 32'd9);

    // 3b: all-zero value shows only digit 0
    value_in   = 16'h0000;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    wait_frame_done();
    step();
    lit = '{0, 0, 0, 0};
    tally();
    for (int k = 0; k < FRAME - 1; k++) begin
      step();
      tally();
    end
    check("t3b_lit_d0", 32'(lit[0]), 32'd8);
    check("t3b_lit_d1", 32'(lit[1]), 32'd0);
    check("t3b_lit_d2", 32'(lit[2]), 32'd0);
    check("t3b_lit_d3", 32'(lit[3]), 32'd0);

    // 5: load accepted on the frame_done cycle commits one frame later
    check("t5_on_boundary", 32'(frame_done), 32'd1);
    value_in   = 16'h8765;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    check("t5_accepted", 32'(load_ready), 32'd0);
    goto_pos(2);
    check("t5_old_persists", 32'(bcd_out), 32'd0);
    goto_pos(12);
    check("t5_old_suppressed", 32'(anode), 32'hF);
    wait_frame_done();
    step();
    goto_pos(2);
    check("t5_new_d0", 32'(bcd_out), 32'd5);
    goto_pos(12);
    check("t5_new_d1", 32'(bcd_out), 32'd6);
    check("t5_new_d1_anode", 32'(anode), 32'hD);

    // 6: enable dropped mid-SHOW of digit 2, re-enable, then async reset
    goto_pos(25);
    enable = 1'b0;
    step();
    check("t6_dark_anode", 32'(anode), 32'hF);
    check("t6_dark_digit", 32'(digit_sel), 32'd0);
    step();
    enable = 1'b1;
    step();
    check("t6_restart_blank", 32'(anode), 32'hF);
    check("t6_restart_digit", 32'(digit_sel), 32'd0);
    step();
    step();
    check("t6_restart_show", 32'(anode), 32'hE);
    value_in   = 16'h1111;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    check("t6_pending_set", 32'(load_ready), 32'd0);
    goto_pos(15);
    #2 reset = 1'b0;
    #1;
    check("t6_async_anode", 32'(anode), 32'hF);
    check("t6_async_digit", 32'(digit_sel), 32'd0);
    check("t6_async_bcd", 32'(bcd_out), 32'd0);
    check("t6_async_frame_done", 32'(frame_done), 32'd0);
    check("t6_async_ready", 32'(load_ready), 32'd1);
    model_reset();
    @(posedge clk_in);
    #1;
    reset = 1'b1;
    wait_frame_done();
    step();
    goto_pos(2);
    check("t6_pending_lost", 32'(bcd_out), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/display_scan_controller.md
Name: display_scan_controller

Overview:
Sequencer for the 4-digit multiplexed seven-segment display path. It replaces the free-running 2-bit scan counter with a controller that handles:
- digit slot timing
- inter-digit blanking (anti-ghosting)
- leading-zero suppression
- a double-buffered load handshake, so the producer (BCD counter) updates the display only at frame boundaries

Its outputs drive the digit mux select, the BCD-to-seven-segment decoder input and the anode lines directly.

Parameters:
- CLK_FREQ, 100000000, input clock frequency in Hz.
- SCAN_FREQ, 1000, digit slot rate in Hz. TICK_DIV = CLK_FREQ/SCAN_FREQ clock cycles per slot.
- N_DIGITS, 4, number of display digits. Minimum 2.
- BLANK_CYCLES, 16, cycles at the start of each slot with all anodes off. Elaboration error unless 0 < BLANK_CYCLES < TICK_DIV.

Ports:
- clk_in  input  1  system clock
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- enable  input  1  1 = scanning runs; 0 = display dark
- blank_lz  input  1  1 = suppress leading zeros
- value_in  input  4*N_DIGITS  BCD digits; digit 0 = bits [3:0] (least significant)
- load_valid  input  1  producer offers value_in
- load_ready  output  1  shadow buffer free
- digit_sel  output  $clog2(N_DIGITS)  index of the digit currently scanned
- bcd_out  output  4  nibble of the active buffer at digit_sel
- anode  output  N_DIGITS  active-low anode enables
- frame_done  output  1  one-cycle pulse when the last digit's slot ends

Behaviour:
- Reset values:
  - state IDLE; timer 0; digit_sel 0; bcd_out 0
  - anode all 1s; frame_done 0; load_ready 1
  - active buffer 0; shadow 0; pending 0
- States:
  - IDLE: anodes off, timer and digit_sel held at 0. Goes to BLANK on the first cycle enable=1.
  - BLANK: anodes off for BLANK_CYCLES cycles (timer 0..BLANK_CYCLES-1), then SHOW.
  - SHOW: runs until timer = TICK_DIV-1. Then timer returns to 0 and digit_sel increments, wrapping N_DIGITS-1 -> 0, and the state returns to BLANK.
- Slot length: exactly TICK_DIV cycles.
- enable=0 in any state: next cycle is IDLE, anodes off, digit_sel 0, timer 0. Shadow and pending are retained.
- anode and bcd_out are registered: they reflect the state and digit_sel of the same cycle, with no extra latency.
- In SHOW, anode[digit_sel] = 0 and all other anodes = 1, unless the digit is suppressed.
- bcd_out = active[digit_sel] in every state. Non-BCD nibbles (>9) pass through unchanged.
- Leading-zero suppression (blank_lz=1): digit i is suppressed if it and all more-significant digits are 0. Digit 0 is never suppressed (value 0 shows "0"). Suppressed digits keep all anodes 1 for their whole slot; timing is unchanged.
- Load handshake:
  - load_ready = ~pending.
  - On load_valid && load_ready: shadow <= value_in and pending <= 1.
  - load_valid held while ready=0 is ignored; the producer must keep holding it.
- Frame boundary (last SHOW cycle of digit N_DIGITS-1):
  - frame_done = 1 for one cycle.
  - If pending: active <= shadow, pending <= 0, so load_ready rises the next cycle.
  - Digit 0 of the next frame shows the new value.
- Load accepted on the frame-boundary cycle (pending was 0): it is captured into shadow and commits at the following frame boundary, not the current one.
- Reset asserted mid-frame: all registers return to their reset values immediately, asynchronously, and any pending load is lost.

Decomposition:
- Package display_pkg:
  - state enum {IDLE, BLANK, SHOW}
  - ANODE_OFF constant
  - function tick_div(clk, freq) and the timer width derived from it
- One natural sub-module, scan_timer: a slot timer that outputs blank_end and slot_end strobes and takes clear from the enable logic.
- The state machine, buffers and suppression logic stay in display_scan_controller.

Test Plan:
Bench parameters: CLK_FREQ=1000, SCAN_FREQ=100 (TICK_DIV=10), BLANK_CYCLES=2, N_DIGITS=4. One frame = 40 cycles.
1. Reset low, then release with enable=1 -> anode=4'b1111 for 2 cycles, then 4'b1110 for 8 cycles, then digit_sel=1 with anode 1111 for 2 cycles, then 1101; frame_done pulses at cycle 40.
2. Load value_in=16'h1234 with load_valid for one cycle while ready=1 -> load_ready=0 until the frame boundary; the next frame shows bcd_out 4,3,2,1 on digits 0..3; load_ready returns to 1 the cycle after frame_done.
3. blank_lz=1 with active=16'h0050 -> digits 3 and 2 keep anode=1111 for their full slots; digit 1 shows 5 and digit 0 shows 0. Same setup with value 16'h0000 -> only digit 0 lights, showing 0.
4. Second load_valid (16'h9999) while pending -> ignored. Holding it through the boundary -> accepted on the cycle ready rises, and displayed one frame later.
5. Load accepted on the exact frame_done cycle -> the old value persists for the next frame; the new value commits at the following frame_done.
6. enable dropped mid-SHOW of digit 2 -> next cycle anode=1111 and digit_sel=0. Re-enable -> restarts with BLANK on digit 0. Async reset mid-SHOW -> outputs go to reset values without waiting for a clock edge.
